// File: rtl/axis_decimator_pkg.sv
// Shared types and helpers for the AXI4-Stream decimator.
package axis_decimator_pkg;

  typedef enum logic {MODE_DROP = 1'b0, MODE_AVERAGE = 1'b1} decim_mode_t;

  localparam int LOG_THROTTLE_WIDTH = 5;

  function automatic logic [LOG_THROTTLE_WIDTH-1:0] clamp_n(
    input logic [LOG_THROTTLE_WIDTH-1:0] n,
    input logic [LOG_THROTTLE_WIDTH-1:0] max_n
  );
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/axis_decimator_channel_acc.sv
// One signed channel of the window accumulator: sums samples and yields the floored mean.
module decim_channel_acc
  import axis_decimator_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 16,
  parameter int ACC_WIDTH     = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          en,
  input  logic                          last,
  input  logic [LOG_THROTTLE_WIDTH-1:0] n,
  input  logic [CHANNEL_WIDTH-1:0]      sample,
  output logic [CHANNEL_WIDTH-1:0]      result
);

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] sum;

  assign sample_ext = {{(ACC_WIDTH-CHANNEL_WIDTH){sample[CHANNEL_WIDTH-1]}}, sample};
  assign sum        = acc_q + sample_ext;
  // The current beat is folded in so the mean is ready on the last beat itself.
  assign result     = CHANNEL_WIDTH'(sum >>> n);

  always_comb begin
    acc_d = acc_q;
    if (en) acc_d = last ? '0 : sum;
  end

  always_ff @(posedge aclk) begin
    if (areset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/axis_decimator.sv
// AXI4-Stream rate reducer by 2^N with DROP and AVERAGE modes, honouring backpressure.
module axis_decimator
  import axis_decimator_pkg::*;
#(
  parameter int CHANNEL_WIDTH    = 16,
  parameter int NUM_CHANNELS     = 2,
  parameter int MAX_LOG_THROTTLE = 16
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [LOG_THROTTLE_WIDTH-1:0]           log_throttle,
  input  logic                                    mode,
  input  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   S_AXIS_tdata,
  input  logic                                    S_AXIS_tvalid,
  output logic                                    S_AXIS_tready,
  output logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   M_AXIS_tdata,
  output logic                                    M_AXIS_tvalid,
  input  logic                                    M_AXIS_tready
);

  localparam int AXIS_TDATA_WIDTH = CHANNEL_WIDTH * NUM_CHANNELS;
  localparam int ACC_WIDTH        = CHANNEL_WIDTH + MAX_LOG_THROTTLE;
  localparam int CNT_W            = MAX_LOG_THROTTLE;
  localparam logic [LOG_THROTTLE_WIDTH-1:0] MAX_N = LOG_THROTTLE_WIDTH'(MAX_LOG_THROTTLE);

  // Handshake: a beat moves on an edge where tvalid && tready are both high;
  // the master holds tdata/tvalid until then and the slave never makes
  // tready depend on tvalid.

  logic [CNT_W-1:0]              cnt_q;
  logic [LOG_THROTTLE_WIDTH-1:0] n_cfg_q;
  decim_mode_t                   mode_cfg_q;
  logic [AXIS_TDATA_WIDTH-1:0]   m_tdata_q;
  logic                          m_tvalid_q;
  logic                          areset_q;

  logic [LOG_THROTTLE_WIDTH-1:0] n_live;
  decim_mode_t                   mode_live;
  logic                          first;
  logic [LOG_THROTTLE_WIDTH-1:0] n_cur;
  decim_mode_t                   mode_cur;
  logic [CNT_W-1:0]              win_mask;
  logic                          last;
  logic                          emit_next;
  logic                          s_ready;
  logic                          accept;
  logic [AXIS_TDATA_WIDTH-1:0]   avg_data;

  // At cnt==0 the window is governed by the live config that is about to be latched.
  always_comb begin
    n_live    = clamp_n(log_throttle, MAX_N);
    mode_live = decim_mode_t'(mode);
    first     = (cnt_q == '0);
    n_cur     = first ? n_live : n_cfg_q;
    mode_cur  = first ? mode_live : mode_cfg_q;
    win_mask  = ~({CNT_W{1'b1}} << n_cur);
    last      = (cnt_q == win_mask);
    emit_next = (mode_cur == MODE_DROP) ? first : last;
    s_ready   = !areset_q && (!m_tvalid_q || M_AXIS_tready || !emit_next);
    accept    = S_AXIS_tvalid && s_ready;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    decim_channel_acc #(
      .CHANNEL_WIDTH (CHANNEL_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
    ) u_acc (
      .aclk   (aclk),
      .areset (areset),
      .en     (accept && (mode_cur == MODE_AVERAGE)),
      .last   (last),
      .n      (n_cur),
      .sample (S_AXIS_tdata[g*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .result (avg_data[g*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q      <= '0;
      n_cfg_q    <= '0;
      mode_cfg_q <= MODE_DROP;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      areset_q   <= 1'b1;
    end else begin
      areset_q <= 1'b0;
      if (accept) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (first) begin
          n_cfg_q    <= n_live;
          mode_cfg_q <= mode_live;
        end
      end
      // A new emit on the handshake edge reloads the register for back-to-back output.
      if (accept && emit_next) begin
        m_tdata_q  <= (mode_cur == MODE_DROP) ? S_AXIS_tdata : avg_data;
        m_tvalid_q <= 1'b1;
      end else if (M_AXIS_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXIS_tready = s_ready;
  assign M_AXIS_tdata  = m_tdata_q;
  assign M_AXIS_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_axis_decimator.sv
// Directed scoreboard bench for axis_decimator: expected beats queued by the driver, popped by a monitor.
module tb_axis_decimator;

  localparam int W = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [4:0]    log_throttle = 5'd0;
  logic          mode = 1'b0;
  logic [W-1:0]  S_tdata = '0;
  logic          S_tvalid = 1'b0;
  logic          S_tready;
  logic [W-1:0]  M_tdata;
  logic          M_tvalid;
  logic          M_tready = 1'b1;

  axis_decimator dut (
    .aclk          (aclk),
    .areset        (areset),
    .log_throttle  (log_throttle),
    .mode          (mode),
    .S_AXIS_tdata  (S_tdata),
    .S_AXIS_tvalid (S_tvalid),
    .S_AXIS_tready (S_tready),
    .M_AXIS_tdata  (M_tdata),
    .M_AXIS_tvalid (M_tvalid),
    .M_AXIS_tready (M_tready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int c1, input int c0);
    return {c1[15:0], c0[15:0]};
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees what the next edge will act on.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge aclk) begin
    if (prev_stall) begin
      check("hold_valid", W'(M_tvalid), W'(1));
      check("hold_data", M_tdata, prev_data);
    end
    if (!areset && M_tvalid && M_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h expected no output", M_tdata);
      end else begin
        check("out_data", M_tdata, exp_q.pop_front());
      end
    end
    prev_stall = !areset && M_tvalid && !M_tready;
    prev_data  = M_tdata;
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [W-1:0] d, output int stalls);
    stalls   = 0;
    S_tdata  = d;
    S_tvalid = 1'b1;
    @(negedge aclk);
    while (!S_tready && stalls < 100) begin
      stalls++;
      @(negedge aclk);
    end
    if (!S_tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got no accept expected accept within 100 cycles");
    end
    @(posedge aclk);
    #1;
    S_tvalid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge aclk);
      k++;
    end
    #1;
    check("drain_empty", W'(exp_q.size()), W'(0));
    repeat (4) @(posedge aclk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int st;
  int st_sum;
  logic [W-1:0] d;

  initial begin
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_m_tvalid", W'(M_tvalid), W'(0));
    check("rst_m_tdata", M_tdata, W'(0));
    check("rst_s_tready", W'(S_tready), W'(0));
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("rel_s_tready", W'(S_tready), W'(1));

    // 1: N=3 DROP ramp
    log_throttle = 5'd3; mode = 1'b0; M_tready = 1'b1;
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(0, 8));
    exp_q.push_back(mk(0, 16));
    exp_q.push_back(mk(0, 24));
    st_sum = 0;
    for (int i = 0; i < 32; i++) begin
      beat(mk(0, i), st);
      st_sum += st;
    end
    check("t1_no_stall", W'(st_sum), W'(0));
    drain();

    // 2: N=2 AVERAGE, floor on negative mean
    log_throttle = 5'd2; mode = 1'b1;
    exp_q.push_back(mk(100, 5));
    exp_q.push_back(mk(100, -2));
    beat(mk(100, 4), st);  beat(mk(100, 5), st);
    beat(mk(100, 6), st);  beat(mk(100, 7), st);
    beat(mk(100, -1), st); beat(mk(100, -2), st);
    beat(mk(100, -2), st); beat(mk(100, -2), st);
    drain();

    // 3: N=0 pass-through, both modes, one-cycle latency
    log_throttle = 5'd0;
    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      for (int i = 0; i < 10; i++) begin
        d = mk(-i, 3 * i + 1);
        exp_q.push_back(d);
        beat(d, st);
        check("t3_lat_valid", W'(M_tvalid), W'(1));
        check("t3_lat_data", M_tdata, d);
      end
      drain();
    end

    // 4: N=1 AVERAGE with downstream stalled for 6 cycles
    log_throttle = 5'd1; mode = 1'b1; M_tready = 1'b0;
    exp_q.push_back(mk(-4, 11));
    exp_q.push_back(mk(7, -7));
    fork
      begin
        st_sum = 0;
        beat(mk(-3, 10), st); st_sum += st;
        beat(mk(-4, 13), st); st_sum += st;
        beat(mk(7, -5), st);  st_sum += st;
        check("t4_nonlast_no_stall", W'(st_sum), W'(0));
        beat(mk(8, -8), st);
        check("t4_last_stalled", W'(st > 0), W'(1));
      end
      begin
        repeat (6) @(posedge aclk);
        #1;
        M_tready = 1'b1;
      end
    join
    drain();

    // 5: log_throttle 3->1 mid-window
    log_throttle = 5'd3; mode = 1'b1;
    exp_q.push_back(mk(0, 4));
    exp_q.push_back(mk(0, 15));
    exp_q.push_back(mk(0, 7));
    for (int i = 1; i <= 5; i++) beat(mk(0, i), st);
    log_throttle = 5'd1;
    for (int i = 6; i <= 8; i++) beat(mk(0, i), st);
    beat(mk(0, 10), st); beat(mk(0, 20), st);
    beat(mk(0, 7), st);  beat(mk(0, 8), st);
    drain();

    // 6: reset mid-window with a pending output
    log_throttle = 5'd2; mode = 1'b0; M_tready = 1'b0;
    beat(mk(1, 111), st);
    beat(mk(2, 222), st);
    check("t6_pending_valid", W'(M_tvalid), W'(1));
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("t6_rst_m_tvalid", W'(M_tvalid), W'(0));
    check("t6_rst_s_tready", W'(S_tready), W'(0));
    check("t6_rst_m_tdata", M_tdata, W'(0));
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("t6_rel_s_tready", W'(S_tready), W'(1));
    M_tready = 1'b1;
    exp_q.push_back(mk(5, 50));
    beat(mk(5, 50), st); beat(mk(6, 60), st);
    beat(mk(7, 70), st); beat(mk(8, 80), st);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
